// File: rtl/mem_stage_store_sequencer_if.sv
// Store-sequencer bus: EX/MEM op inputs (with forwarded sources and selects),
// memory/framebuffer byte-write side, SFR write side and pipeline status.
//   master : pipeline + memory side (drives op fields and mem_ack)
//   slave  : the store sequencer
interface mem_stage_store_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned SFR_AW = 8
);
  logic              op_valid;
  logic [7:0]        opcode;
  logic [1:0]        subop;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       src_rf;
  logic [15:0]       src_exmem;
  logic [15:0]       src_memwb;
  logic [15:0]       src_imm;
  logic [3:0]        sel_top;
  logic [3:0]        sel_bot;
  logic              sfr_sel;
  logic              mem_ack;
  logic              dmem_we;
  logic              fb_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              sfr_we;
  logic [SFR_AW-1:0] sfr_addr;
  logic [7:0]        sfr_data;
  logic              stall;
  logic              done;
  logic              illegal_op;
  logic [ADDR_W-1:0] sp;

  modport master (
    output op_valid, opcode, subop, addr, src_rf, src_exmem, src_memwb, src_imm,
           sel_top, sel_bot, sfr_sel, mem_ack,
    input  dmem_we, fb_we, wr_addr, wr_data, sfr_we, sfr_addr, sfr_data,
           stall, done, illegal_op, sp
  );

  modport slave (
    input  op_valid, opcode, subop, addr, src_rf, src_exmem, src_memwb, src_imm,
           sel_top, sel_bot, sfr_sel, mem_ack,
    output dmem_we, fb_we, wr_addr, wr_data, sfr_we, sfr_addr, sfr_data,
           stall, done, illegal_op, sp
  );
endinterface

// File: rtl/mem_stage_store_sequencer.sv
// Memory-stage store sequencer. Resolves the 16-bit store datum from the
// forwarded sources, writes it as two bytes to data memory or framebuffer
// (or one byte to an SFR for out), stalls upstream until retire, and owns
// the hardware stack pointer used by push.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : op inputs, byte-write outputs, SFR outputs, stall/done/illegal_op/sp
module mem_stage_store_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(16'hFFFF),
  parameter int unsigned       SFR_AW   = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  mem_stage_store_sequencer_if.slave     bus
);
  localparam logic [7:0] OPC_STORE = 8'hC4;
  localparam logic [7:0] OPC_OUT   = 8'h9C;
  localparam logic [1:0] SUB_STORE = 2'd0;
  localparam logic [1:0] SUB_FB    = 2'd1;
  localparam logic [1:0] SUB_PUSH  = 2'd2;

  typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        byte1_q;
  logic              dmem_we_q;
  logic              fb_we_q;
  logic              push_q;

  logic [15:0] top_src, bot_src;
  logic [7:0]  data_hi, data_lo;
  logic        sel_ok, is_c4, is_out, is_store, is_fb, is_push, mem_op, idle;
  logic        do_start, do_out, do_illegal, done_c;

  // One-hot {imm,memwb,exmem,rf} source mux; zero/multi-hot yields 0.
  function automatic logic [15:0] mux_src(input logic [3:0] sel, input logic [15:0] rf,
                                          input logic [15:0] ex, input logic [15:0] mw,
                                          input logic [15:0] im);
    mux_src = 16'h0000;
    case (sel)
      4'b0001: mux_src = rf;
      4'b0010: mux_src = ex;
      4'b0100: mux_src = mw;
      4'b1000: mux_src = im;
      default: mux_src = 16'h0000;
    endcase
  endfunction

  // Op decode and datum resolution from the current inputs.
  always_comb begin
    top_src    = mux_src(bus.sel_top, bus.src_rf, bus.src_exmem, bus.src_memwb, bus.src_imm);
    bot_src    = mux_src(bus.sel_bot, bus.src_rf, bus.src_exmem, bus.src_memwb, bus.src_imm);
    data_hi    = top_src[15:8];
    data_lo    = bot_src[7:0];
    sel_ok     = $onehot(bus.sel_top) && $onehot(bus.sel_bot);
    is_c4      = (bus.opcode == OPC_STORE);
    is_out     = (bus.opcode == OPC_OUT);
    is_store   = is_c4 && (bus.subop == SUB_STORE);
    is_fb      = is_c4 && (bus.subop == SUB_FB);
    is_push    = is_c4 && (bus.subop == SUB_PUSH);
    mem_op     = (is_store || is_fb || is_push) && sel_ok;
    idle       = (state_q == IDLE);
    do_start   = idle && bus.op_valid && mem_op;
    do_out     = idle && bus.op_valid && is_out;
    do_illegal = idle && bus.op_valid && !mem_op && !is_out;
    // out/illegal retire in the accept cycle; memory ops on the second ack
    done_c     = do_out || do_illegal || ((state_q == BYTE1) && bus.mem_ack);
  end

  // Byte sequencer and stack pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sp_q      <= SP_RESET;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      byte1_q   <= 8'h00;
      dmem_we_q <= 1'b0;
      fb_we_q   <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (do_start) begin
            state_q   <= BYTE0;
            dmem_we_q <= !is_fb;
            fb_we_q   <= is_fb;
            push_q    <= is_push;
            // push stores big-end first downward from sp; store/FB little-end upward
            if (is_push) begin
              wr_addr_q <= sp_q;
              wr_data_q <= data_hi;
              byte1_q   <= data_lo;
            end else begin
              wr_addr_q <= bus.addr;
              wr_data_q <= data_lo;
              byte1_q   <= data_hi;
            end
          end
        end
        BYTE0: begin
          if (bus.mem_ack) begin
            state_q   <= BYTE1;
            wr_addr_q <= push_q ? (wr_addr_q - ADDR_W'(1)) : (wr_addr_q + ADDR_W'(1));
            wr_data_q <= byte1_q;
          end
        end
        BYTE1: begin
          if (bus.mem_ack) begin
            state_q   <= IDLE;
            dmem_we_q <= 1'b0;
            fb_we_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            if (push_q) sp_q <= sp_q - ADDR_W'(2);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dmem_we    = dmem_we_q;
  assign bus.fb_we      = fb_we_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.sp         = sp_q;
  assign bus.sfr_we     = do_out;
  assign bus.sfr_addr   = do_out ? bus.addr[SFR_AW-1:0] : '0;
  assign bus.sfr_data   = do_out ? (bus.sfr_sel ? bus.src_exmem[7:0] : bus.src_rf[7:0]) : 8'h00;
  assign bus.done       = done_c;
  assign bus.illegal_op = do_illegal;
  assign bus.stall      = bus.op_valid && !done_c;
endmodule

// File: tb/tb_mem_stage_store_sequencer.sv
// Scoreboard bench for mem_stage_store_sequencer: the driver pushes the
// expected byte writes and retire records; a negedge monitor pops and compares.
module tb_mem_stage_store_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_stage_store_sequencer_if #(.ADDR_W(16), .SFR_AW(8)) bus();

  mem_stage_store_sequencer #(.ADDR_W(16), .SP_RESET(16'hFFFF), .SFR_AW(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {logic [1:0] kind; logic [15:0] addr; logic [7:0] data;} wr_t;
  typedef struct packed {logic ill; logic [15:0] sp;} ret_t;

  wr_t  exp_wr[$];
  ret_t exp_ret[$];
  int   runs[$];
  int   nchk = 0;
  int   npass = 0;
  int   ack_mode = 0;
  int   ack_cnt = 0;
  int   run_len = 0;
  logic [15:0] model_sp = 16'hFFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // mem_ack generator: 0 random, 1 always, 2 never, 3 hold off 3 strobe cycles, 4 manual
  always @(posedge clock) begin
    #1;
    case (ack_mode)
      0: bus.mem_ack = ($urandom_range(0, 3) != 0);
      1: bus.mem_ack = 1'b1;
      2: bus.mem_ack = 1'b0;
      3: begin
        if (bus.dmem_we || bus.fb_we) ack_cnt++;
        bus.mem_ack = (ack_cnt > 3);
      end
      default: ;
    endcase
  end

  task automatic pop_wr(input wr_t act);
    wr_t e;
    if (exp_wr.size() == 0) chk("write_unexpected", 32'(act), 32'hFFFF_FFFF);
    else begin
      e = exp_wr.pop_front();
      chk("write", 32'(act), 32'(e));
    end
  endtask

  // Monitor: every accepted byte write, SFR write and retire is checked.
  always @(negedge clock) begin
    if (!reset_n) run_len = 0;
    else begin
      if (bus.dmem_we && bus.fb_we) chk("dmem_and_fb", 32'd1, 32'd0);
      if ((bus.dmem_we || bus.fb_we) && bus.sfr_we) chk("mem_and_sfr", 32'd1, 32'd0);
      if (bus.dmem_we || bus.fb_we) begin
        run_len++;
        if (!bus.mem_ack) chk("stall_busy", 32'(bus.stall), 32'd1);
        else begin
          runs.push_back(run_len);
          run_len = 0;
          pop_wr('{kind: {1'b0, bus.fb_we}, addr: bus.wr_addr, data: bus.wr_data});
        end
      end
      if (bus.sfr_we) pop_wr('{kind: 2'd2, addr: {8'h00, bus.sfr_addr}, data: bus.sfr_data});
      if (bus.done) begin
        if (exp_ret.size() == 0) chk("retire_unexpected", 32'd1, 32'd0);
        else begin
          ret_t r;
          r = exp_ret.pop_front();
          chk("illegal_op", 32'(bus.illegal_op), 32'(r.ill));
          chk("sp", 32'(bus.sp), 32'(r.sp));
          chk("stall_at_done", 32'(bus.stall), 32'd0);
        end
      end else if (bus.illegal_op) chk("illegal_without_done", 32'd1, 32'd0);
    end
  end

  // Reference model (expected writes/retire) followed by drive-until-done.
  task automatic do_op(input logic [7:0] opc, input logic [1:0] sub, input logic [15:0] a,
                       input logic [15:0] rf, input logic [15:0] ex, input logic [15:0] mw,
                       input logic [15:0] im, input logic [3:0] st, input logic [3:0] sb,
                       input logic ss, output int lat);
    logic [15:0] srcs[4];
    logic [7:0]  hi, lo;
    logic [1:0]  kind;
    bit          ok;
    int          n;
    srcs = '{rf, ex, mw, im};
    hi = 8'h00;
    lo = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (st == 4'(1 << i)) hi = srcs[i][15:8];
      if (sb == 4'(1 << i)) lo = srcs[i][7:0];
    end
    if (opc == 8'h9C) begin
      exp_wr.push_back('{kind: 2'd2, addr: {8'h00, a[7:0]}, data: (ss ? ex[7:0] : rf[7:0])});
      exp_ret.push_back('{ill: 1'b0, sp: model_sp});
    end else if (opc == 8'hC4 && sub != 2'd3 && $countones(st) == 1 && $countones(sb) == 1) begin
      if (sub == 2'd2) begin
        exp_wr.push_back('{kind: 2'd0, addr: model_sp, data: hi});
        exp_wr.push_back('{kind: 2'd0, addr: model_sp - 16'd1, data: lo});
        exp_ret.push_back('{ill: 1'b0, sp: model_sp});
        model_sp = model_sp - 16'd2;
      end else begin
        kind = (sub == 2'd1) ? 2'd1 : 2'd0;
        exp_wr.push_back('{kind: kind, addr: a, data: lo});
        exp_wr.push_back('{kind: kind, addr: a + 16'd1, data: hi});
        exp_ret.push_back('{ill: 1'b0, sp: model_sp});
      end
    end else exp_ret.push_back('{ill: 1'b1, sp: model_sp});

    bus.op_valid = 1'b1; bus.opcode = opc; bus.subop = sub; bus.addr = a;
    bus.src_rf = rf; bus.src_exmem = ex; bus.src_memwb = mw; bus.src_imm = im;
    bus.sel_top = st; bus.sel_bot = sb; bus.sfr_sel = ss;
    ok = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clock);
      if (bus.done) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) chk("op_timeout", 32'd0, 32'd1);
    lat = n;
    @(posedge clock); #1;
    bus.op_valid = 1'b0;
    bus.opcode = 8'($urandom);
    bus.addr = 16'($urandom);
  endtask

  int lat;

  initial begin
    bus.op_valid = 1'b0; bus.opcode = 8'h00; bus.subop = 2'd0; bus.addr = 16'h0;
    bus.src_rf = 16'h0; bus.src_exmem = 16'h0; bus.src_memwb = 16'h0; bus.src_imm = 16'h0;
    bus.sel_top = 4'b0001; bus.sel_bot = 4'b0001; bus.sfr_sel = 1'b0; bus.mem_ack = 1'b0;
    #12;
    chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
    chk("rst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("rst_sfr_we", 32'(bus.sfr_we), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_sfr_addr", 32'(bus.sfr_addr), 32'd0);
    chk("rst_sfr_data", 32'(bus.sfr_data), 32'd0);
    chk("rst_done_stall", {30'd0, bus.done, bus.stall}, 32'd0);
    chk("rst_sp", 32'(bus.sp), 32'hFFFF);
    @(posedge clock); #3; reset_n = 1'b1;
    @(posedge clock); #1;

    // push straight out of reset
    ack_mode = 1;
    do_op(8'hC4, 2'd2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 4'b1000, 4'b1000, 1'b0, lat);
    chk("push_sp_after", 32'(bus.sp), 32'hFFFD);
    chk("push_latency", 32'(lat), 32'd2);

    // plain store, hi from exmem, lo from rf
    do_op(8'hC4, 2'd0, 16'h1000, 16'h00AA, 16'hBB00, 16'h0, 16'h0, 4'b0010, 4'b0001, 1'b0, lat);
    chk("store_latency", 32'(lat), 32'd2);

    // out to SFR, single cycle
    do_op(8'h9C, 2'd0, 16'h0042, 16'h0011, 16'h0077, 16'h0, 16'h0, 4'b0001, 4'b0001, 1'b1, lat);
    chk("out_latency", 32'(lat), 32'd0);

    // illegal opcode and multi-hot select
    do_op(8'h00, 2'd0, 16'h2000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0001, 4'b0001, 1'b0, lat);
    chk("illegal_opc_latency", 32'(lat), 32'd0);
    do_op(8'hC4, 2'd0, 16'h2000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0011, 4'b0001, 1'b0, lat);
    chk("illegal_sel_sp", 32'(bus.sp), 32'hFFFD);

    // store-FB at top of memory with a delayed first ack
    ack_cnt = 0; ack_mode = 3;
    runs.delete();
    do_op(8'hC4, 2'd1, 16'hFFFF, 16'h0000, 16'h0000, 16'hC35A, 16'h0000, 4'b0100, 4'b0100, 1'b0, lat);
    chk("fb_byte0_cycles", 32'(runs.size() > 0 ? runs[0] : 0), 32'd4);
    chk("fb_byte1_cycles", 32'(runs.size() > 1 ? runs[1] : 0), 32'd1);

    // reset in the second byte of a push
    ack_mode = 4; bus.mem_ack = 1'b0;
    bus.op_valid = 1'b1; bus.opcode = 8'hC4; bus.subop = 2'd2;
    bus.src_imm = 16'hABCD; bus.sel_top = 4'b1000; bus.sel_bot = 4'b1000;
    exp_wr.push_back('{kind: 2'd0, addr: model_sp, data: 8'hAB});
    @(posedge clock); #1; bus.mem_ack = 1'b1;
    @(posedge clock); #1; bus.mem_ack = 1'b0;
    #2; reset_n = 1'b0;
    #1;
    chk("abort_strobes", {30'd0, bus.dmem_we, bus.fb_we}, 32'd0);
    chk("abort_sp", 32'(bus.sp), 32'hFFFF);
    chk("abort_done", 32'(bus.done), 32'd0);
    bus.op_valid = 1'b0;
    model_sp = 16'hFFFF;
    @(posedge clock); #3; reset_n = 1'b1;
    @(posedge clock); #1;
    ack_mode = 0;
    do_op(8'hC4, 2'd2, 16'h0, 16'h5678, 16'h0, 16'h0, 16'h0, 4'b0001, 4'b0001, 1'b0, lat);
    chk("after_abort_sp", 32'(bus.sp), 32'hFFFD);

    // randomized ops with random acks and idle gaps
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [7:0] opc;
      logic [3:0] st, sb;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      opc = (r < 7) ? 8'hC4 : (r < 9) ? 8'h9C : 8'($urandom);
      st = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      sb = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      do_op(opc, 2'($urandom_range(0, 3)), a, 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), st, sb, 1'($urandom), lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    repeat (3) @(posedge clock);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("ret_queue_empty", 32'(exp_ret.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
